pipe_stage_buf: RTL

Parametrised pipeline stage register with valid/ready handshaking, an optional 2-entry skid buffer, and a flush path that inserts a bubble while preserving the PC field. It is the generic successor to the fixed-field inter-stage registers. It sits between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and replaces the global stall bit with per-stage backpressure. It also counts instructions discarded by flushes for performance monitoring.

---
 rtl/pipe_stage_buf.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage register with valid/ready backpressure,
// optional 2-entry skid buffer and a PC-preserving flush bubble.
module pipe_stage_buf #(
  parameter int                      ADDR_WIDTH     = 32,
  parameter int                      DATA_WIDTH     = 128,
  parameter int                      CTRL_WIDTH     = 12,
  parameter logic [CTRL_WIDTH-1:0]   CTRL_RESET_VAL = 12'h000,
  parameter logic [ADDR_WIDTH-1:0]   PC_ADDR        = 32'h8000_0000,
  parameter bit                      SKID           = 1'b1,
  parameter int                      CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [ADDR_WIDTH-1:0] up_pc,
  input  logic [CTRL_WIDTH-1:0] up_ctrl,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [ADDR_WIDTH-1:0] dn_pc,
  output logic [CTRL_WIDTH-1:0] dn_ctrl,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic [1:0]            occupancy,
  output logic [CNT_WIDTH-1:0]  flush_drops
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  logic [1:0]            r_occ;
  logic                  r_up_ready;
  logic [ADDR_WIDTH-1:0] r_m_pc;
  logic [CTRL_WIDTH-1:0] r_m_ctrl;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ADDR_WIDTH-1:0] r_s_pc;
  logic [CTRL_WIDTH-1:0] r_s_ctrl;
  logic [DATA_WIDTH-1:0] r_s_data;
  logic [CNT_WIDTH-1:0]  r_drops;

  logic                  w_up_ready;
  logic                  w_dn_valid;
  logic                  w_in;
  logic                  w_out;
  logic [1:0]            w_held;
  logic [1:0]            w_inc;
  logic [CNT_WIDTH:0]    w_sum;
  logic [CNT_WIDTH-1:0]  w_drops_nxt;

  // Skid mode uses the registered ready; plain mode passes dn_ready through.
  assign w_dn_valid = (r_state != ST_EMPTY);
  assign w_up_ready = SKID ? r_up_ready
                           : (!w_dn_valid | dn_ready);
  assign w_in  = up_valid & w_up_ready;
  assign w_out = w_dn_valid & dn_ready;

  // Entries lost by a flush: held ones not leaving, plus the one arriving.
  assign w_held = r_occ - {1'b0, w_out};
  assign w_inc  = w_held + {1'b0, w_in};
  assign w_sum  = {1'b0, r_drops}
                + {{(CNT_WIDTH-1){1'b0}}, w_inc};
  assign w_drops_nxt = w_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}}
                                        : w_sum[CNT_WIDTH-1:0];

  // Occupancy FSM with head/skid storage, flush bubble and drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_EMPTY;
      r_occ      <= 2'd0;
      r_up_ready <= 1'b1;
      r_m_pc     <= PC_ADDR;
      r_m_ctrl   <= CTRL_RESET_VAL;
      r_m_data   <= '0;
      r_s_pc     <= '0;
      r_s_ctrl   <= CTRL_RESET_VAL;
      r_s_data   <= '0;
      r_drops    <= '0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_occ      <= 2'd0;
      r_up_ready <= 1'b1;
      r_m_pc     <= up_pc;
      r_m_ctrl   <= CTRL_RESET_VAL;
      r_m_data   <= '0;
      r_drops    <= w_drops_nxt;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in) begin
            r_m_pc   <= up_pc;
            r_m_ctrl <= up_ctrl;
            r_m_data <= up_data;
            r_state  <= ST_ONE;
            r_occ    <= 2'd1;
          end
        end
        ST_ONE: begin
          if (w_in && w_out) begin
            r_m_pc   <= up_pc;
            r_m_ctrl <= up_ctrl;
            r_m_data <= up_data;
          end else if (w_in && SKID) begin
            r_s_pc     <= up_pc;
            r_s_ctrl   <= up_ctrl;
            r_s_data   <= up_data;
            r_state    <= ST_TWO;
            r_occ      <= 2'd2;
            r_up_ready <= 1'b0;
          end else if (w_out) begin
            r_m_ctrl <= CTRL_RESET_VAL;
            r_state  <= ST_EMPTY;
            r_occ    <= 2'd0;
          end
        end
        ST_TWO: begin
          if (w_out) begin
            r_m_pc     <= r_s_pc;
            r_m_ctrl   <= r_s_ctrl;
            r_m_data   <= r_s_data;
            r_state    <= ST_ONE;
            r_occ      <= 2'd1;
            r_up_ready <= 1'b1;
          end
        end
        default: begin
          r_m_ctrl   <= CTRL_RESET_VAL;
          r_state    <= ST_EMPTY;
          r_occ      <= 2'd0;
          r_up_ready <= 1'b1;
        end
      endcase
    end
  end

  assign up_ready    = w_up_ready;
  assign dn_valid    = w_dn_valid;
  assign dn_pc       = r_m_pc;
  assign dn_ctrl     = r_m_ctrl;
  assign dn_data     = r_m_data;
  assign occupancy   = r_occ;
  assign flush_drops = r_drops;

endmodule
